// File: rtl/uncached_write_buffer_if.sv
// SRAM-like request/response bus used on both sides of the uncached write
// buffer. The master issues requests and the slave returns responses.
//   req     : request valid (master -> slave)
//   wr      : 1 = write, 0 = read
//   size    : access size, carried through unchanged
//   addr    : physical address
//   wdata   : write data
//   rdata   : read data, qualified by data_ok on a read completion
//   addr_ok : request accepted this cycle (req & addr_ok)
//   data_ok : one completion pulse per accepted request
interface uncached_write_buffer_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/uncached_write_buffer.sv
// Uncached write buffer between the CPU uncached data port and the
// SRAM-like-to-AXI converter. Uncached stores are posted into a small FIFO
// and acknowledged one cycle after acceptance, so the CPU never waits on the
// AXI write. Uncached reads are held off until every posted write has been
// issued and completed downstream, which keeps strict program order.
//
// Ports:
//   aclk     : sole clock, rising edge
//   aresetn  : asynchronous active-low reset
//   s        : upstream bus (this block is the slave), CPU side
//   m        : downstream bus (this block is the master), converter side
//
// Parameter:
//   DEPTH    : write FIFO entries, power of two in 2..16
module uncached_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  uncached_write_buffer_if.slave  s,
  uncached_write_buffer_if.master m
);

  localparam int PW = $clog2(DEPTH);  // pointer width
  localparam int CW = PW + 1;         // entry count width
  localparam int OW = PW + 2;         // outstanding write counter width
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  // Control state
  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [OW-1:0]   wr_out_q, wr_out_d;
  logic            wr_ack_q, wr_ack_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic [1:0]      rd_size_q, rd_size_d;

  // FIFO storage; contents are qualified by count_q, so no reset needed
  logic [31:0]     addr_mem  [DEPTH];
  logic [1:0]      size_mem  [DEPTH];
  logic [31:0]     wdata_mem [DEPTH];

  logic            in_idle;
  logic            fifo_full;
  logic            fifo_empty;
  logic            wr_ok;
  logic            rd_ok;
  logic            push;
  logic            rd_accept;
  logic            drain;
  logic            pop;
  logic            rd_done;
  logic            wr_resp;

  always_comb begin
    in_idle    = (state_q == IDLE);
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);

    // Writes are refused while a read is in progress so they cannot
    // overtake it; a full FIFO blocks a push even if a pop happens now.
    wr_ok      = in_idle && !fifo_full;
    // A read waits until every earlier write is issued (FIFO empty),
    // completed downstream (wr_out zero) and acknowledged upstream
    // (wr_ack zero), so the read completion is strictly ordered.
    rd_ok      = in_idle && fifo_empty && (wr_out_q == '0) && !wr_ack_q;

    push       = s.req && s.wr && wr_ok;
    rd_accept  = s.req && !s.wr && rd_ok;

    drain      = in_idle && !fifo_empty;
    pop        = drain && m.addr_ok;

    // Only one read can be in flight and it issues with no writes
    // outstanding, so any data_ok outside RD_WAIT belongs to a write.
    rd_done    = (state_q == RD_WAIT) && m.data_ok;
    wr_resp    = m.data_ok && (state_q != RD_WAIT);
  end

  // Upstream responses
  assign s.addr_ok = s.wr ? wr_ok : rd_ok;
  assign s.data_ok = wr_ack_q || rd_done;
  assign s.rdata   = rd_done ? m.rdata : 32'h0;

  // Downstream request mux: FIFO head while draining, latched read in RD_REQ
  always_comb begin
    m.req   = 1'b0;
    m.wr    = 1'b0;
    m.size  = 2'b00;
    m.addr  = 32'h0;
    m.wdata = 32'h0;
    if (drain) begin
      m.req   = 1'b1;
      m.wr    = 1'b1;
      m.size  = size_mem[rptr_q];
      m.addr  = addr_mem[rptr_q];
      m.wdata = wdata_mem[rptr_q];
    end else if (state_q == RD_REQ) begin
      m.req   = 1'b1;
      m.size  = rd_size_q;
      m.addr  = rd_addr_q;
    end
  end

  // Next-state logic
  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    wr_out_d  = wr_out_q;
    wr_ack_d  = push;
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;

    // Pointers wrap naturally because DEPTH is a power of two
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case ({pop, wr_resp})
      2'b10:   wr_out_d = wr_out_q + OW'(1);
      2'b01:   wr_out_d = wr_out_q - OW'(1);
      default: wr_out_d = wr_out_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (rd_accept) begin
          rd_addr_d = s.addr;
          rd_size_d = s.size;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        if (m.addr_ok) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (m.data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wr_out_q  <= '0;
      wr_ack_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_size_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      wr_out_q  <= wr_out_d;
      wr_ack_q  <= wr_ack_d;
      rd_addr_q <= rd_addr_d;
      rd_size_q <= rd_size_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge aclk) begin
    if (push) begin
      addr_mem[wptr_q]  <= s.addr;
      size_mem[wptr_q]  <= s.size;
      wdata_mem[wptr_q] <= s.wdata;
    end
  end

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Self-checking bench for uncached_write_buffer. A CPU-side driver issues
// directed and random requests; a downstream responder emulates the
// SRAM-like-to-AXI converter with configurable accept and completion timing.
// A monitor keeps a transaction-level reference model (queues of pending
// work plus a few counters) and scoreboards every DUT output.
module tb_uncached_write_buffer;

  localparam int DEPTH = 4;

  logic aclk;
  logic aresetn;

  uncached_write_buffer_if up_if ();
  uncached_write_buffer_if dn_if ();

  uncached_write_buffer #(.DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (up_if),
    .m       (dn_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit is_rd;
    int cyc;
  } cmp_t;

  // Scoreboard / reference model state
  req_t  down_q[$];   // accepted upstream requests not yet taken downstream
  cmp_t  comp_q[$];   // upstream completions still owed
  int    resp_q[$];   // cycle at which each downstream completion may fire
  int    wr_out_m;    // writes taken downstream, not yet completed
  int    rstate;      // 0 no read, 1 read waiting to issue, 2 read awaiting data
  bit    wr_ack_m;    // a write was accepted in the previous cycle
  int    cyc;

  // Responder controls
  int          aok_mode;     // 0 never accept, 1 always accept, 2 random
  int          fixed_dly;    // <0 random completion delay
  bit          force_en;
  logic [31:0] force_rdata;
  logic [31:0] last_rd_data;

  int n_checks;
  int n_pass;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  always @(posedge aclk) cyc++;

  // Downstream converter emulation
  initial begin
    dn_if.addr_ok = 1'b0;
    dn_if.data_ok = 1'b0;
    dn_if.rdata   = 32'h0;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        resp_q.delete();
        dn_if.addr_ok = 1'b0;
        dn_if.data_ok = 1'b0;
      end else begin
        case (aok_mode)
          0:       dn_if.addr_ok = 1'b0;
          1:       dn_if.addr_ok = 1'b1;
          default: dn_if.addr_ok = (($urandom % 4) != 0);
        endcase
        if (resp_q.size() > 0 && resp_q[0] <= cyc) begin
          void'(resp_q.pop_front());
          dn_if.data_ok = 1'b1;
          dn_if.rdata   = force_en ? force_rdata : $urandom;
        end else begin
          dn_if.data_ok = 1'b0;
          dn_if.rdata   = $urandom;
        end
      end
    end
  end

  // Monitor and reference model, sampled mid-cycle
  bit   rd_cpl, exp_aok, exp_mreq, exp_sdok, acc_up, acc_dn;
  req_t h;
  cmp_t c;
  int   dly;

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_m_req", 32'(dn_if.req), 0);
      chk("rst_s_data_ok", 32'(up_if.data_ok), 0);
      chk("rst_s_rdata", up_if.rdata, 0);
      if (up_if.req) chk("rst_s_addr_ok", 32'(up_if.addr_ok), 1);
      down_q.delete();
      comp_q.delete();
      resp_q.delete();
      wr_out_m = 0;
      rstate   = 0;
      wr_ack_m = 1'b0;
    end else begin
      rd_cpl   = (rstate == 2) && dn_if.data_ok;
      exp_sdok = wr_ack_m || rd_cpl;
      exp_mreq = (rstate == 1) || (rstate == 0 && down_q.size() > 0);

      if (up_if.req) begin
        if (up_if.wr) exp_aok = (rstate == 0) && (down_q.size() < DEPTH);
        else exp_aok = (rstate == 0) && (down_q.size() == 0) && (wr_out_m == 0) && !wr_ack_m;
        chk(up_if.wr ? "s_addr_ok_wr" : "s_addr_ok_rd", 32'(up_if.addr_ok), 32'(exp_aok));
      end
      chk("m_req", 32'(dn_if.req), 32'(exp_mreq));
      chk("s_data_ok", 32'(up_if.data_ok), 32'(exp_sdok));
      chk("s_rdata", up_if.rdata, rd_cpl ? dn_if.rdata : 32'h0);

      if (up_if.data_ok) begin
        chk("cpl_owed", 32'(comp_q.size() != 0), 1);
        if (comp_q.size() != 0) begin
          c = comp_q.pop_front();
          chk("cpl_kind", 32'(rd_cpl), 32'(c.is_rd));
          if (!c.is_rd) chk("wr_cpl_cycle", cyc, c.cyc);
          else last_rd_data = up_if.rdata;
        end
      end

      // Downstream completion
      if (dn_if.data_ok) begin
        if (rstate == 2) rstate = 0;
        else wr_out_m--;
      end

      // Downstream request taken
      acc_dn = dn_if.req && dn_if.addr_ok;
      if (acc_dn) begin
        chk("dn_expected", 32'(down_q.size() != 0), 1);
        if (down_q.size() != 0) begin
          h = down_q.pop_front();
          chk("m_wr", 32'(dn_if.wr), 32'(h.wr));
          chk("m_size", 32'(dn_if.size), 32'(h.size));
          chk("m_addr", dn_if.addr, h.addr);
          chk("m_wdata", dn_if.wdata, h.wr ? h.wdata : 32'h0);
          if (h.wr) wr_out_m++;
          else rstate = 2;
          dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
          resp_q.push_back(cyc + 1 + dly);
        end
      end

      // Upstream request accepted
      acc_up = up_if.req && up_if.addr_ok;
      if (acc_up) begin
        h.wr    = up_if.wr;
        h.size  = up_if.size;
        h.addr  = up_if.addr;
        h.wdata = up_if.wdata;
        down_q.push_back(h);
        c.is_rd = !up_if.wr;
        c.cyc   = cyc + 1;
        comp_q.push_back(c);
        if (!up_if.wr) rstate = 1;
      end
      wr_ack_m = acc_up && up_if.wr;
    end
  end

  // Driver tasks: each starts and ends just after a rising edge
  task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] dat, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    up_if.req   = 1'b1;
    up_if.wr    = wr;
    up_if.size  = sz;
    up_if.addr  = a;
    up_if.wdata = dat;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      acc = up_if.req && up_if.addr_ok;
      @(posedge aclk);
      #1;
      if (acc) break;
      waited++;
    end
    up_if.req = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (down_q.size() == 0 && comp_q.size() == 0 && resp_q.size() == 0) break;
      @(posedge aclk);
      #1;
    end
    chk("drain_done", 32'(down_q.size() + comp_q.size() + resp_q.size()), 0);
    idle(2);
  endtask

  task automatic do_reset();
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_m_req", 32'(dn_if.req), 0);
    chk("async_rst_s_data_ok", 32'(up_if.data_ok), 0);
    chk("async_rst_s_rdata", up_if.rdata, 0);
    up_if.req = 1'b1;
    up_if.wr  = 1'b1;
    @(negedge aclk);
    #1;
    up_if.wr = 1'b0;
    @(negedge aclk);
    #1;
    up_if.req = 1'b0;
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int w;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    wr_out_m = 0;
    rstate   = 0;
    wr_ack_m = 1'b0;
    aok_mode = 1;
    fixed_dly = -1;
    force_en = 1'b0;
    force_rdata = 32'h0;
    last_rd_data = 32'h0;
    up_if.req = 1'b0;
    up_if.wr = 1'b0;
    up_if.size = 2'b00;
    up_if.addr = 32'h0;
    up_if.wdata = 32'h0;
    aresetn = 1'b1;
    #1;
    aresetn = 1'b0;
    up_if.req = 1'b1;
    up_if.wr = 1'b1;
    @(negedge aclk);
    #1;
    up_if.wr = 1'b0;
    @(negedge aclk);
    #1;
    up_if.req = 1'b0;
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Single posted write, downstream always accepting
    aok_mode = 1;
    issue(1'b1, 2'd2, 32'h1FAF_F000, 32'hDEAD_BEEF, w);
    wait_drain();

    // Five back-to-back writes with downstream stalled: fifth must wait
    aok_mode = 0;
    for (int i = 0; i < 4; i++) issue(1'b1, 2'd2, 32'h1FAF_F100 + 32'(i * 4), 32'hA000_0000 + 32'(i), w);
    fork
      issue(1'b1, 2'd2, 32'h1FAF_F110, 32'hA000_0004, w);
      begin
        repeat (6) @(posedge aclk);
        aok_mode = 1;
      end
    join
    chk("fifth_write_waited", 32'(w >= 5), 1);
    wait_drain();

    // Write then read with slow write completion: read waits on wr_out
    fixed_dly = 5;
    issue(1'b1, 2'd2, 32'h1FAF_F000, 32'h0BAD_F00D, w);
    issue(1'b0, 2'd2, 32'h1FAF_F004, 32'h0, w);
    chk("read_held_for_write", 32'(w >= 5), 1);
    wait_drain();
    fixed_dly = -1;

    // Read with known data, then a write that must wait for it
    force_en = 1'b1;
    force_rdata = 32'h1234_5678;
    fixed_dly = 3;
    issue(1'b0, 2'd1, 32'h1FAF_F008, 32'h0, w);
    issue(1'b1, 2'd0, 32'h1FAF_F00C, 32'h5555_AAAA, w);
    chk("write_held_for_read", 32'(w >= 3), 1);
    wait_drain();
    chk("read_data_value", last_rd_data, 32'h1234_5678);
    force_en = 1'b0;
    fixed_dly = -1;

    // Ten writes with random downstream accept: push/pop overlap and wrap
    aok_mode = 2;
    for (int i = 0; i < 10; i++) issue(1'b1, 2'(i), 32'h1FAF_F200 + 32'(i * 4), $urandom, w);
    wait_drain();

    // Random mix of reads and writes
    for (int i = 0; i < 250; i++) begin
      issue(($urandom % 4) != 0, 2'($urandom), $urandom, $urandom, w);
      if (($urandom % 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    wait_drain();

    // Reset with three writes buffered and an ack pending
    aok_mode = 0;
    for (int i = 0; i < 3; i++) issue(1'b1, 2'd2, 32'h1FAF_F300 + 32'(i * 4), $urandom, w);
    do_reset();
    aok_mode = 1;
    idle(10);

    // Reset while a read waits for its data
    fixed_dly = 8;
    issue(1'b0, 2'd2, 32'h1FAF_F400, 32'h0, w);
    idle(2);
    do_reset();
    fixed_dly = -1;
    idle(12);

    // Recovery after reset
    aok_mode = 2;
    issue(1'b1, 2'd3, 32'h1FAF_F500, 32'hCAFE_0001, w);
    issue(1'b0, 2'd2, 32'h1FAF_F504, 32'h0, w);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
